// File: rtl/memoria_instrucciones_cargable.sv
// IF-stage instruction memory: 1-cycle synchronous fetch with stall/flush, plus a
// run-time program-load port driven by a two-state EJECUTAR/CARGAR controller.
module memoria_instrucciones_cargable #(
  parameter int                    ANCHO_DATO  = 32,
  parameter int                    ANCHO_DIR   = 10,
  parameter int                    PROFUNDIDAD = 1024,
  parameter logic [ANCHO_DATO-1:0] NOP         = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ANCHO_DIR-1:0]  direccion,
  input  logic                  leer,
  input  logic                  congelar,
  input  logic                  limpiar,
  output logic [ANCHO_DATO-1:0] instruccion,
  output logic                  valido,
  output logic                  fuera_rango,
  input  logic                  cargar_inicio,
  input  logic                  cargar_en,
  input  logic [ANCHO_DATO-1:0] cargar_dato,
  input  logic                  cargar_fin,
  output logic                  cargando,
  output logic [ANCHO_DIR:0]    cargar_cuenta,
  output logic                  cargar_lleno
);

  localparam int                 AW     = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
  localparam logic [ANCHO_DIR:0] LIMITE = (ANCHO_DIR + 1)'(PROFUNDIDAD);
  localparam logic [ANCHO_DIR:0] UNO    = {{ANCHO_DIR{1'b0}}, 1'b1};

  // state | meaning
  // EJECUTAR | normal fetch operation, load port idle
  // CARGAR   | program load in progress, fetch path frozen at NOP/invalid
  localparam logic [0:0] EJECUTAR = 1'b0;
  localparam logic [0:0] CARGAR   = 1'b1;

  logic [0:0]            estado;
  logic [ANCHO_DIR:0]    cuenta;
  logic                  dentro_rango;
  logic                  hay_espacio;
  logic                  escribir;

  // Power-up content is NOP everywhere; reset deliberately leaves the array alone.
  logic [ANCHO_DATO-1:0] rom [PROFUNDIDAD] = '{default: NOP};

  assign dentro_rango = {1'b0, direccion} < LIMITE;
  assign hay_espacio  = cuenta < LIMITE;
  assign escribir     = !reset && (estado == CARGAR) && !cargar_inicio && cargar_en && hay_espacio;

  assign cargando      = (estado == CARGAR);
  assign cargar_cuenta = cuenta;
  assign cargar_lleno  = (cuenta == LIMITE);

  always_ff @(posedge clk) begin
    if (escribir) begin
      rom[cuenta[AW-1:0]] <= cargar_dato;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= EJECUTAR;
      cuenta      <= '0;
      instruccion <= NOP;
      valido      <= 1'b0;
      fuera_rango <= 1'b0;
    end else if (estado == EJECUTAR) begin
      if (cargar_inicio) begin
        estado      <= CARGAR;
        cuenta      <= '0;
        instruccion <= NOP;
        valido      <= 1'b0;
        fuera_rango <= 1'b0;
      end else if (limpiar) begin
        instruccion <= NOP;
        valido      <= 1'b0;
        fuera_rango <= 1'b0;
      end else if (!congelar) begin
        if (leer) begin
          valido <= 1'b1;
          if (dentro_rango) begin
            instruccion <= rom[direccion[AW-1:0]];
            fuera_rango <= 1'b0;
          end else begin
            instruccion <= NOP;
            fuera_rango <= 1'b1;
          end
        end else begin
          valido <= 1'b0;
        end
      end
    end else begin
      valido <= 1'b0;
      // A restart wins over both the write strobe and the exit request.
      if (cargar_inicio) begin
        cuenta <= '0;
      end else begin
        if (cargar_en && hay_espacio) begin
          cuenta <= cuenta + UNO;
        end
        if (cargar_fin) begin
          estado <= EJECUTAR;
        end
      end
    end
  end

endmodule
